// File: rtl/bit_packer_if.sv
// AXI-stream word bundle driven by bit_packer toward the framer.
interface bit_packer_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;

   modport master (
      output tdata,
      output tvalid,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      output tready
   );
endinterface

// File: rtl/bit_packer.sv
// Packs 0..IN_WIDTH recovered bits per clk into DATA_WIDTH-bit AXI-stream words.
// Optional BIT_PACKER_STATS_EN adds drop_count and word_count outputs.
module bit_packer #(
   parameter int DATA_WIDTH = 32,
   parameter int IN_WIDTH   = 2,
   parameter int CNT_W      = $clog2(IN_WIDTH + 1)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [IN_WIDTH-1:0] in_bits,
   input  logic [CNT_W-1:0]    in_count,
   input  logic                resync,
   bit_packer_if.master        m_axis,
   output logic                overflow,
   output logic [$clog2(DATA_WIDTH+IN_WIDTH+1)-1:0] fill_level
`ifdef BIT_PACKER_STATS_EN
   ,
   output logic [15:0]         drop_count,
   output logic [31:0]         word_count
`endif
);

   localparam int ACC_W  = DATA_WIDTH + IN_WIDTH;
   localparam int FILL_W = $clog2(DATA_WIDTH + IN_WIDTH + 1);

   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_shift;
   logic [ACC_W-1:0]  acc_next;
   logic [ACC_W-1:0]  new_bits;
   logic [FILL_W-1:0] fill;
   logic [FILL_W-1:0] fill_post;
   logic [FILL_W-1:0] fill_next;
   logic [FILL_W:0]   fill_sum;
   logic [CNT_W-1:0]  cnt;
   logic              slot_free;
   logic              do_ext;
   logic              drop;

   // Bits above fill are kept zero, so append is a plain OR.
   always_comb begin
      cnt = in_count;
      if (in_count > CNT_W'(IN_WIDTH)) begin
         cnt = '0;
      end
      new_bits = '0;
      for (int i = 0; i < IN_WIDTH; i++) begin
         if (CNT_W'(i) < cnt) begin
            new_bits[i] = in_bits[i];
         end
      end
      slot_free = !m_axis.tvalid || m_axis.tready;
      do_ext    = slot_free && !resync &&
                  (fill >= FILL_W'(DATA_WIDTH));
      acc_shift = do_ext ? (acc >> DATA_WIDTH) : acc;
      fill_post = do_ext ? (fill - FILL_W'(DATA_WIDTH)) : fill;
      fill_sum  = {1'b0, fill} + (FILL_W+1)'(cnt);
      drop      = !do_ext && (fill_sum > (FILL_W+1)'(ACC_W));
      acc_next  = acc_shift | (new_bits << fill_post);
      fill_next = fill_post + FILL_W'(cnt);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc           <= '0;
         fill          <= '0;
         overflow      <= 1'b0;
         m_axis.tdata  <= '0;
         m_axis.tvalid <= 1'b0;
      end else begin
         if (do_ext) begin
            m_axis.tdata  <= acc[DATA_WIDTH-1:0];
            m_axis.tvalid <= 1'b1;
         end else if (m_axis.tvalid && m_axis.tready) begin
            m_axis.tvalid <= 1'b0;
         end
         if (resync) begin
            acc      <= '0;
            fill     <= '0;
            overflow <= 1'b0;
         end else if (drop) begin
            overflow <= 1'b1;
         end else begin
            acc  <= acc_next;
            fill <= fill_next;
         end
      end
   end

   assign fill_level = fill;

`ifdef BIT_PACKER_STATS_EN
   logic [16:0] drop_sum;

   assign drop_sum = {1'b0, drop_count} + 17'(cnt);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         drop_count <= '0;
         word_count <= '0;
      end else begin
         if (m_axis.tvalid && m_axis.tready) begin
            word_count <= word_count + 32'd1;
         end
         if (resync) begin
            drop_count <= '0;
         end else if (drop) begin
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
         end
      end
   end
`endif

endmodule

// File: tb/tb_bit_packer.sv
// Randomized bench for bit_packer against a bit-queue reference model.
module tb_bit_packer;

   localparam int DW  = 32;
   localparam int IW  = 2;
   localparam int ACW = DW + IW;

   logic       clk;
   logic       reset_n;
   logic [1:0] in_bits;
   logic [1:0] in_count;
   logic       resync;
   logic       overflow;
   logic [5:0] fill_level;
`ifdef BIT_PACKER_STATS_EN
   logic [15:0] drop_count;
   logic [31:0] word_count;
`endif

   bit_packer_if #(.DATA_WIDTH(DW)) axis ();

   bit_packer #(
      .DATA_WIDTH(DW),
      .IN_WIDTH  (IW)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_bits   (in_bits),
      .in_count  (in_count),
      .resync    (resync),
      .m_axis    (axis),
      .overflow  (overflow),
      .fill_level(fill_level)
`ifdef BIT_PACKER_STATS_EN
      ,
      .drop_count(drop_count),
      .word_count(word_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int errors;

   bit          q[$];
   bit          m_valid;
   bit [31:0]   m_data;
   bit          m_ovf;
   int          m_drop;
   longint      m_words;

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit [1:0] b, input int cn,
                             input bit rs, input bit rdy,
                             input bit rst);
      int c;
      bit ext;
      bit [31:0] w;
      if (!rst) begin
         q.delete();
         m_valid = 0;
         m_data  = 0;
         m_ovf   = 0;
         m_drop  = 0;
         m_words = 0;
         return;
      end
      if (m_valid && rdy) m_words++;
      c = (cn > IW) ? 0 : cn;
      ext = (!m_valid || rdy) && !rs && (q.size() >= DW);
      if (ext) begin
         for (int i = 0; i < DW; i++) w[i] = q.pop_front();
         m_data  = w;
         m_valid = 1;
      end else if (m_valid && rdy) begin
         m_valid = 0;
      end
      if (rs) begin
         q.delete();
         m_ovf  = 0;
         m_drop = 0;
      end else if (!ext && (q.size() + c > ACW)) begin
         m_ovf  = 1;
         m_drop = (m_drop + c > 65535) ? 65535 : m_drop + c;
      end else begin
         for (int i = 0; i < c; i++) q.push_back(b[i]);
      end
   endtask

   task automatic cycle(input logic [1:0] b, input logic [1:0] cn,
                        input logic rs, input logic rdy,
                        input logic rst);
      in_bits     = b;
      in_count    = cn;
      resync      = rs;
      axis.tready = rdy;
      reset_n     = rst;
      @(posedge clk);
      model_step(b, int'(cn), rs, rdy, rst);
      #1;
      check("tvalid", 64'(axis.tvalid), 64'(m_valid));
      check("tdata", 64'(axis.tdata), 64'(m_data));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("fill", 64'(fill_level), 64'(q.size()));
`ifdef BIT_PACKER_STATS_EN
      check("drop_count", 64'(drop_count), 64'(m_drop));
      check("word_count", 64'(word_count), 64'(m_words[31:0]));
`endif
   endtask

   task automatic do_reset();
      cycle(2'b00, 2'd0, 1'b0, 1'b1, 1'b0);
      cycle(2'b00, 2'd0, 1'b0, 1'b1, 1'b0);
   endtask

   int unsigned ctr_val;
   int          ctr_idx;

   function automatic bit next_ctr_bit();
      bit r;
      r = ctr_val[ctr_idx];
      ctr_idx++;
      if (ctr_idx == 32) begin
         ctr_idx = 0;
         ctr_val++;
      end
      return r;
   endfunction

   initial begin
      int first;
      int last;
      int maxfill;
      int pat[4];
      logic [31:0] held;
      logic [1:0] b;
      logic [5:0] f0;
      checks      = 0;
      errors      = 0;
      in_bits     = '0;
      in_count    = '0;
      resync      = 1'b0;
      axis.tready = 1'b1;
      reset_n     = 1'b0;
      q.delete();

      do_reset();
      check("rst_tvalid", 64'(axis.tvalid), 64'd0);
      check("rst_tdata", 64'(axis.tdata), 64'd0);
      check("rst_fill", 64'(fill_level), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);

      first = 0;
      last  = 0;
      for (int k = 1; k <= 80; k++) begin
         cycle(2'b01, 2'd2, 1'b0, 1'b1, 1'b1);
         if (axis.tvalid) begin
            check("word55", 64'(axis.tdata), 64'h5555_5555);
            if (first == 0) first = k;
            if (last != 0) check("period", 64'(k - last), 64'd16);
            last = k;
         end
      end
      check("first_latency", 64'(first), 64'd17);
      check("ovf_stays0", 64'(overflow), 64'd0);

      do_reset();
      pat = '{1, 2, 1, 0};
      ctr_val = 32'h0000_0001;
      ctr_idx = 0;
      maxfill = 0;
      for (int k = 0; k < 240; k++) begin
         b = 2'b00;
         for (int i = 0; i < pat[k % 4]; i++) b[i] = next_ctr_bit();
         cycle(b, 2'(pat[k % 4]), 1'b0, 1'b1, 1'b1);
         if (int'(fill_level) > maxfill) maxfill = int'(fill_level);
      end
      check("fill_le_33", 64'(maxfill <= 33), 64'd1);

      do_reset();
      for (int k = 0; k < 17; k++) cycle(2'b10, 2'd2, 1'b0, 1'b0, 1'b1);
      held = axis.tdata;
      check("held_word", 64'(held), 64'hAAAA_AAAA);
      for (int k = 0; k < 16; k++) begin
         cycle(2'(k), 2'd2, 1'b0, 1'b0, 1'b1);
         check("held_stable", 64'(axis.tdata), 64'(held));
      end
      check("fill_34", 64'(fill_level), 64'd34);
      check("no_ovf_yet", 64'(overflow), 64'd0);
      for (int k = 0; k < 3; k++) cycle(2'b11, 2'd2, 1'b0, 1'b0, 1'b1);
      check("ovf_set", 64'(overflow), 64'd1);
      check("fill_kept", 64'(fill_level), 64'd34);
`ifdef BIT_PACKER_STATS_EN
      check("drop_6", 64'(drop_count), 64'd6);
`endif
      for (int k = 0; k < 60; k++)
         cycle(2'($urandom), 2'd2, 1'b0, 1'b1, 1'b1);

      do_reset();
      for (int k = 0; k < 26; k++) cycle(2'b01, 2'd2, 1'b0, 1'b0, 1'b1);
      check("fill_20", 64'(fill_level), 64'd20);
      held = axis.tdata;
      cycle(2'b11, 2'd2, 1'b1, 1'b0, 1'b1);
      check("rs_fill0", 64'(fill_level), 64'd0);
      check("rs_pending", 64'(axis.tvalid), 64'd1);
      check("rs_ovf0", 64'(overflow), 64'd0);
      cycle(2'b10, 2'd2, 1'b0, 1'b1, 1'b1);
      check("rs_word", 64'(held), 64'h5555_5555);
      for (int k = 0; k < 17; k++) begin
         cycle(2'b10, 2'd2, 1'b0, 1'b1, 1'b1);
         if (axis.tvalid) check("rs_next", 64'(axis.tdata), 64'hAAAA_AAAA);
      end

      for (int k = 0; k < 20; k++) cycle(2'b01, 2'd2, 1'b0, 1'b0, 1'b1);
      cycle(2'b01, 2'd2, 1'b0, 1'b0, 1'b0);
      check("mr_tvalid0", 64'(axis.tvalid), 64'd0);
      check("mr_fill0", 64'(fill_level), 64'd0);
      for (int k = 0; k < 17; k++) cycle(2'b11, 2'd2, 1'b0, 1'b0, 1'b1);
      check("mr_word", 64'(axis.tdata), 64'hFFFF_FFFF);
      check("mr_valid", 64'(axis.tvalid), 64'd1);

      do_reset();
      for (int k = 0; k < 5; k++) cycle(2'b01, 2'd1, 1'b0, 1'b1, 1'b1);
      f0 = fill_level;
      for (int k = 0; k < 5; k++) begin
         cycle(2'b11, 2'd3, 1'b0, 1'b1, 1'b1);
         check("ill_fill", 64'(fill_level), 64'(f0));
         check("ill_novalid", 64'(axis.tvalid), 64'd0);
      end

      for (int k = 0; k < 3000; k++) begin
         cycle(2'($urandom), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 99) < 2),
               1'($urandom_range(0, 99) < 60),
               1'($urandom_range(0, 999) >= 5));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
